// File: rtl/ntt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ntt_pkg
//  Description : Shared constants and FSM encoding for the NTT BRAM stream
//                reader and its FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
package ntt_pkg;

    localparam int C_D_SIZE_DEFAULT  = 52;
    localparam int C_Q_DEPTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } rdr_state_t;

endpackage
`default_nettype wire

// File: rtl/bram_rdr_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : bram_rdr_fifo
//  Description : Two-entry synchronous FIFO holding words captured from BRAM
//                while the downstream stream is stalled.
//  Revision    : 1.0  initial release
// ============================================================================
module bram_rdr_fifo
    import ntt_pkg::*;
#(
    parameter int D_SIZE = C_D_SIZE_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [D_SIZE-1:0] din,
    input  logic              pop,
    output logic [D_SIZE-1:0] dout,
    output logic [1:0]        count
);

    logic [D_SIZE-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_do_pop  = pop && (r_count != 2'd0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = push && ((r_count != 2'd2) || w_do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_do_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : bram_stream_reader
//  Description : Reads a burst of len words from a posedge BRAM starting at
//                base and streams them out with valid/ready and a last flag.
//                Define BRAM_RDR_BITREV_EN for bit-reversed address order.
//  Revision    : 1.0  initial release
// ============================================================================
module bram_stream_reader
    import ntt_pkg::*;
#(
    parameter int D_SIZE  = C_D_SIZE_DEFAULT,
    parameter int Q_DEPTH = C_Q_DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [Q_DEPTH-1:0] base,
    input  logic [Q_DEPTH:0]   len,
    output logic               busy,
    output logic               done,
    output logic [Q_DEPTH-1:0] rd_addr,
    input  logic [D_SIZE-1:0]  rd_dout,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_SIZE-1:0]  out_data,
    output logic               out_last
);

    rdr_state_t         r_state;
    rdr_state_t         w_state_next;

    logic [Q_DEPTH-1:0] r_base;
    logic [Q_DEPTH:0]   r_len;
    logic [Q_DEPTH:0]   r_idx;
    logic [Q_DEPTH-1:0] r_rd_addr;
    logic               r_inflight;
    logic               r_inflight_last;

    logic [Q_DEPTH-1:0] w_offset;
    logic [Q_DEPTH-1:0] w_rd_addr_next;
    logic [1:0]         w_fifo_count;
    logic [D_SIZE:0]    w_fifo_din;
    logic [D_SIZE:0]    w_fifo_dout;
    logic               w_fifo_empty;
    logic               w_fifo_push;
    logic               w_fifo_pop;
    logic               w_pop;
    logic [2:0]         w_occ;
    logic               w_issue;
    logic               w_last_issue;

`ifdef BRAM_RDR_BITREV_EN
    genvar gi;
    generate
        for (gi = 0; gi < Q_DEPTH; gi++) begin : g_bitrev
            assign w_offset[gi] = r_idx[Q_DEPTH-1-gi];
        end
    endgenerate
`else
    assign w_offset = r_idx[Q_DEPTH-1:0];
`endif

    assign w_rd_addr_next = r_base + w_offset;

    // The word arriving on rd_dout is offered directly when the FIFO is
    // empty, which gives the one-word-per-cycle two-cycle start latency.
    assign w_fifo_empty = (w_fifo_count == 2'd0);
    assign out_valid    = !w_fifo_empty || r_inflight;
    assign w_pop        = out_valid && out_ready;
    assign w_fifo_din   = {r_inflight_last, rd_dout};
    assign w_fifo_pop   = w_pop && !w_fifo_empty;
    assign w_fifo_push  = r_inflight && !(w_fifo_empty && w_pop);

    assign {out_last, out_data} = !w_fifo_empty ? w_fifo_dout :
                                  (r_inflight  ? w_fifo_din  : '0);

    // Words held or on their way must never exceed the two FIFO slots.
    assign w_occ        = {1'b0, w_fifo_count} + {2'b00, r_inflight};
    assign w_issue      = (r_state == S_RUN) && ((w_occ - {2'b00, w_pop}) < 3'd2);
    assign w_last_issue = w_issue && (r_idx == (r_len - 1'b1));

    assign rd_addr = w_issue ? w_rd_addr_next : r_rd_addr;

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last_issue) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (w_pop && out_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_base          <= '0;
            r_len           <= '0;
            r_idx           <= '0;
            r_rd_addr       <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_last_issue;
            if ((r_state == S_IDLE) && start) begin
                r_base <= base;
                r_len  <= len;
                r_idx  <= '0;
            end
            if (w_issue) begin
                r_rd_addr <= w_rd_addr_next;
                r_idx     <= r_idx + 1'b1;
            end
        end
    end

    bram_rdr_fifo #(
        .D_SIZE (D_SIZE + 1)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_fifo_push),
        .din   (w_fifo_din),
        .pop   (w_fifo_pop),
        .dout  (w_fifo_dout),
        .count (w_fifo_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_stream_reader
//  Description : Self-checking bench for bram_stream_reader with a BRAM model
//                and a queue-based stream reference.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bram_stream_reader;

`ifdef BRAM_RDR_BITREV_EN
    localparam int Q = 3;
`else
    localparam int Q = 8;
`endif
    localparam int D     = 52;
    localparam int DEPTH = 1 << Q;

    typedef struct packed {
        logic         last;
        logic [D-1:0] data;
    } beat_t;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         start     = 1'b0;
    logic [Q-1:0] base      = '0;
    logic [Q:0]   len       = '0;
    logic         out_ready = 1'b1;
    logic         busy;
    logic         done;
    logic         out_valid;
    logic         out_last;
    logic [Q-1:0] rd_addr;
    logic [D-1:0] rd_dout = '0;
    logic [D-1:0] out_data;

    logic [D-1:0] mem [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;
    int n_beats  = 0;
    int n_done   = 0;
    int ready_mode = 0;
    int ready_ph   = 0;

    beat_t    exp_q[$];
    logic     m_busy = 1'b0;
    logic     m_done = 1'b0;
    logic     hold_v = 1'b0;
    logic [D:0] hold_val = '0;

    bram_stream_reader #(
        .D_SIZE  (D),
        .Q_DEPTH (Q)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base      (base),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .rd_addr   (rd_addr),
        .rd_dout   (rd_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_dout <= mem[rd_addr];

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1: begin
                out_ready = ((ready_ph % 3) == 0);
                ready_ph++;
            end
            2: out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b1;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Position of word i in the burst relative to base.
    function automatic logic [Q-1:0] ord_of(input int i);
        logic [Q-1:0] v;
        logic [Q-1:0] r;
        v = i[Q-1:0];
`ifdef BRAM_RDR_BITREV_EN
        for (int b = 0; b < Q; b++) r[b] = v[Q-1-b];
`else
        r = v;
`endif
        return r;
    endfunction

    // Reference: compare outputs every cycle, then predict the next cycle.
    always @(negedge clk) begin
        beat_t        b;
        logic         pop_last;
        logic [Q-1:0] a;
        check("busy", 64'(busy), 64'(m_busy));
        check("done", 64'(done), 64'(m_done));
        if (!m_busy) check("idle_valid", 64'(out_valid), 64'(0));
        if (hold_v) begin
            check("hold_valid", 64'(out_valid), 64'(1));
            check("hold_data", 64'({out_last, out_data}), 64'(hold_val));
        end
        pop_last = 1'b0;
        if (out_valid && out_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got data 0x%0h with no beat expected at %0t", out_data, $time);
            end else begin
                b = exp_q.pop_front();
                check("beat", 64'({out_last, out_data}), 64'(b));
                pop_last = b.last;
                n_beats++;
            end
        end
        hold_v   = out_valid && !out_ready && rst_n;
        hold_val = {out_last, out_data};
        if (done) n_done++;
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            exp_q.delete();
        end else if (!m_busy && !m_done && start) begin
            for (int i = 0; i < int'(len); i++) begin
                a = base + ord_of(i);
                exp_q.push_back({(i == int'(len) - 1), mem[a]});
            end
            m_busy = (len != '0);
            m_done = (len == '0);
        end else if (m_busy && pop_last) begin
            m_busy = 1'b0;
            m_done = 1'b1;
        end else begin
            m_done = 1'b0;
        end
    end

    task automatic start_burst(input logic [Q-1:0] b, input logic [Q:0] l);
        base  = b;
        len   = l;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, input bit noise);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            @(posedge clk);
            #1;
            if (noise && !seen) begin
                start = ($urandom_range(0, 3) == 0);
                base  = Q'($urandom);
                len   = (Q+1)'($urandom_range(0, DEPTH));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s: done not seen within %0d cycles", name, budget);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int b0;
        int d0;
        int lmax;
        logic [63:0] r64;
        logic [Q:0]  l;
        for (int i = 0; i < DEPTH; i++) begin
            r64    = {$urandom(), $urandom()};
            mem[i] = r64[D-1:0];
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_last", 64'(out_last), 64'(0));
        check("rst_addr", 64'(rd_addr), 64'(0));
        check("rst_data", 64'(out_data), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // base 0, len 4, ready high: fixed cycle-by-cycle timeline
        ready_mode = 0;
        start_burst('0, (Q+1)'(4));
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
`ifndef BRAM_RDR_BITREV_EN
            if (k <= 4) check("lin4_addr", 64'(rd_addr), 64'(k - 1));
`endif
            check("lin4_valid", 64'(out_valid), 64'(k >= 2 && k <= 5));
            check("lin4_last", 64'(out_last), 64'(k == 5));
            check("lin4_done", 64'(done), 64'(k == 6));
            @(posedge clk);
            #1;
        end

`ifndef BRAM_RDR_BITREV_EN
        begin
            logic [Q-1:0] exp_a [4];
            exp_a = '{8'd254, 8'd255, 8'd0, 8'd1};
            start_burst(8'd254, 9'd4);
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                check("wrap_addr", 64'(rd_addr), 64'(exp_a[k-1]));
                @(posedge clk);
                #1;
            end
            wait_done("wrap_done", 10, 1'b0);
        end
`else
        begin
            logic [Q-1:0] exp_a [8];
            exp_a = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
            start_burst(3'd0, 4'd8);
            for (int k = 1; k <= 8; k++) begin
                @(negedge clk);
                check("bitrev_addr", 64'(rd_addr), 64'(exp_a[k-1]));
                @(posedge clk);
                #1;
            end
            wait_done("bitrev_done", 10, 1'b0);
        end
`endif

        // len 8 under a 1,0,0 ready pattern
        ready_mode = 1;
        ready_ph   = 0;
        b0 = n_beats;
        start_burst(Q'($urandom), (Q+1)'(8));
        wait_done("stall_done", 100, 1'b0);
        check("stall_beats", 64'(n_beats - b0), 64'(8));
        ready_mode = 0;

        // len 0 finishes straight away
        start_burst(Q'(5), '0);
        @(negedge clk);
        check("len0_done", 64'(done), 64'(1));
        check("len0_busy", 64'(busy), 64'(0));
        check("len0_valid", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;

        // start while busy is ignored
        b0 = n_beats;
        d0 = n_done;
        start_burst(Q'(2), (Q+1)'(6));
        @(posedge clk);
        #1 start = 1'b1;
        base = '0;
        len  = (Q+1)'(3);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("ign_done", 30, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("ign_beats", 64'(n_beats - b0), 64'(6));
        check("ign_dones", 64'(n_done - d0), 64'(1));

        // reset asserted on the third beat of a long burst
        l = (Q+1)'((DEPTH < 16) ? DEPTH : 16);
        b0 = n_beats;
        start_burst('0, l);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst3_valid_before", 64'(out_valid), 64'(1));
        check("rst3_beats_before", 64'(n_beats - b0), 64'(2));
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst3_busy", 64'(busy), 64'(0));
        check("rst3_valid", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        b0 = n_beats;
        start_burst(Q'(3), (Q+1)'(2));
        wait_done("after_rst_done", 10, 1'b0);
        check("after_rst_beats", 64'(n_beats - b0), 64'(2));

        // randomized bursts, random ready, random start noise
        ready_mode = 2;
        lmax = (DEPTH < 24) ? DEPTH : 24;
        for (int n = 0; n < 14; n++) begin
            if (n == 0)          l = (Q+1)'(DEPTH);
            else if (n % 5 == 4) l = '0;
            else                 l = (Q+1)'($urandom_range(1, lmax));
            b0 = n_beats;
            start_burst(Q'($urandom), l);
            wait_done("rand_done", 4 * DEPTH + 50, 1'b1);
            check("rand_beats", 64'(n_beats - b0), 64'(l));
        end
        ready_mode = 0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
